// File: rtl/bypass_pkg.sv
// Shared constants, slot-tag type and eligibility helper for the bypass network.
package bypass_pkg;

  // Per-source operand select encodings.
  localparam logic [1:0] FWD_ORI = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  // Architectural zero register; never a forwarding source.
  localparam int unsigned REG_ZERO = 0;

  // Control part of a pipeline slot tag; the destination index is kept alongside
  // so the tag stays independent of REG_ADDR_W.
  typedef struct packed {
    logic valid;
    logic we;
    logic is_load;
  } slot_tag_t;

  // A slot can supply a value only if it holds a real register-writing instruction.
  function automatic logic tag_eligible(slot_tag_t tag, logic dst_is_zero);
    return tag.valid && tag.we && !dst_is_zero;
  endfunction

endpackage

// File: rtl/bypass_network_if.sv
// ID/EX-side bus of the bypass network: slave = bypass block, master = pipeline.
interface bypass_network_if #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned REG_ADDR_W = 5
);
  logic                          flush;
  logic                          id_valid;
  logic [NUM_SRC*REG_ADDR_W-1:0] id_src_addr;
  logic [REG_ADDR_W-1:0]         id_dst_addr;
  logic                          id_dst_we;
  logic                          id_is_load;
  logic [NUM_SRC*DATA_W-1:0]     ex_src_data;
  logic [DATA_W-1:0]             mem_alu_out;
  logic [DATA_W-1:0]             wb_result;
  logic                          stall;
  logic [NUM_SRC*DATA_W-1:0]     ex_src_fwd;
  logic [NUM_SRC*2-1:0]          fwd_sel;

  modport master (
    output flush, id_valid, id_src_addr, id_dst_addr, id_dst_we, id_is_load,
    output ex_src_data, mem_alu_out, wb_result,
    input  stall, ex_src_fwd, fwd_sel
  );

  modport slave (
    input  flush, id_valid, id_src_addr, id_dst_addr, id_dst_we, id_is_load,
    input  ex_src_data, mem_alu_out, wb_result,
    output stall, ex_src_fwd, fwd_sel
  );
endinterface

// File: rtl/fwd_select.sv
// Operand select for one EX source: MEM result (non-load), else WB result, else ID/EX value.
module fwd_select
  import bypass_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] src_addr_i,
  input  logic [DATA_W-1:0]     ori_data_i,
  input  logic                  mem_elig_i,
  input  logic                  mem_is_load_i,
  input  logic [REG_ADDR_W-1:0] mem_dst_i,
  input  logic [DATA_W-1:0]     mem_data_i,
  input  logic                  wb_elig_i,
  input  logic [REG_ADDR_W-1:0] wb_dst_i,
  input  logic [DATA_W-1:0]     wb_data_i,
  output logic [1:0]            sel_o,
  output logic [DATA_W-1:0]     data_o
);

  // Priority mux: MEM is the younger producer; a load in MEM has no data yet.
  always_comb begin
    sel_o  = FWD_ORI;
    data_o = ori_data_i;
    if (mem_elig_i && !mem_is_load_i && (mem_dst_i == src_addr_i)) begin
      sel_o  = FWD_MEM;
      data_o = mem_data_i;
    end else if (wb_elig_i && (wb_dst_i == src_addr_i)) begin
      sel_o  = FWD_WB;
      data_o = wb_data_i;
    end
  end

endmodule

// File: rtl/bypass_network.sv
// Operand forwarding and load-use interlock for the 5-stage pipeline.
// Optional statistics counters are built when FWD_STATS_EN is defined.
module bypass_network
  import bypass_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned REG_ADDR_W = 5
`ifdef FWD_STATS_EN
  ,
  parameter int unsigned CNT_W      = 32
`endif
) (
  input  logic             clk,
  input  logic             rst,
  bypass_network_if.slave  bus
`ifdef FWD_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] fwd_mem_cnt,
  output logic [CNT_W-1:0] fwd_wb_cnt
`endif
);

  localparam logic [REG_ADDR_W-1:0] RegZero = REG_ADDR_W'(REG_ZERO);

  slot_tag_t                     ex_tag_q, ex_tag_d, mem_tag_q, wb_tag_q;
  logic [REG_ADDR_W-1:0]         ex_dst_q, ex_dst_d, mem_dst_q, wb_dst_q;
  logic [NUM_SRC*REG_ADDR_W-1:0] ex_src_q, ex_src_d;
  logic                          ex_elig, mem_elig, wb_elig;
  logic                          src_hit, stall;
  logic [1:0]                    sel      [NUM_SRC];
  logic [DATA_W-1:0]             fwd_data [NUM_SRC];

  assign ex_elig  = tag_eligible(ex_tag_q, ex_dst_q == RegZero);
  assign mem_elig = tag_eligible(mem_tag_q, mem_dst_q == RegZero);
  assign wb_elig  = tag_eligible(wb_tag_q, wb_dst_q == RegZero);

  // Load-use interlock: an ID source matches a load still in EX.
  always_comb begin
    src_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.id_src_addr[i*REG_ADDR_W +: REG_ADDR_W] == ex_dst_q) src_hit = 1'b1;
    end
    stall = bus.id_valid && !bus.flush && ex_elig && ex_tag_q.is_load && src_hit;
  end

  assign bus.stall = stall;

  // EX slot next state: take ID unless stalled or squashed, then insert a bubble.
  always_comb begin
    ex_tag_d = '0;
    ex_dst_d = '0;
    ex_src_d = '0;
    if (!stall && !bus.flush) begin
      ex_tag_d.valid   = bus.id_valid;
      ex_tag_d.we      = bus.id_dst_we;
      ex_tag_d.is_load = bus.id_is_load;
      ex_dst_d         = bus.id_dst_addr;
      ex_src_d         = bus.id_src_addr;
    end
  end

  // Tag shift register EX -> MEM -> WB.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_tag_q  <= '0;
      ex_dst_q  <= '0;
      ex_src_q  <= '0;
      mem_tag_q <= '0;
      mem_dst_q <= '0;
      wb_tag_q  <= '0;
      wb_dst_q  <= '0;
    end else begin
      ex_tag_q  <= ex_tag_d;
      ex_dst_q  <= ex_dst_d;
      ex_src_q  <= ex_src_d;
      mem_tag_q <= ex_tag_q;
      mem_dst_q <= ex_dst_q;
      wb_tag_q  <= mem_tag_q;
      wb_dst_q  <= mem_dst_q;
    end
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    fwd_select #(
      .DATA_W     (DATA_W),
      .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_select (
      .src_addr_i    (ex_src_q[g*REG_ADDR_W +: REG_ADDR_W]),
      .ori_data_i    (bus.ex_src_data[g*DATA_W +: DATA_W]),
      .mem_elig_i    (mem_elig),
      .mem_is_load_i (mem_tag_q.is_load),
      .mem_dst_i     (mem_dst_q),
      .mem_data_i    (bus.mem_alu_out),
      .wb_elig_i     (wb_elig),
      .wb_dst_i      (wb_dst_q),
      .wb_data_i     (bus.wb_result),
      .sel_o         (sel[g]),
      .data_o        (fwd_data[g])
    );
  end

  // Pack per-source results onto the bus.
  always_comb begin
    bus.ex_src_fwd = '0;
    bus.fwd_sel    = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      bus.ex_src_fwd[i*DATA_W +: DATA_W] = fwd_data[i];
      bus.fwd_sel[i*2 +: 2]              = sel[i];
    end
  end

`ifndef SYNTHESIS
  logic missed_interlock;

  // A load in MEM feeding a live EX source means the interlock was bypassed.
  always_comb begin
    missed_interlock = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (ex_tag_q.valid && mem_elig && mem_tag_q.is_load &&
          (ex_src_q[i*REG_ADDR_W +: REG_ADDR_W] == mem_dst_q)) begin
        missed_interlock = 1'b1;
      end
    end
  end

  a_no_load_in_mem_use: assert property (@(posedge clk) disable iff (rst) !missed_interlock);
`endif

`ifdef FWD_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] fwd_mem_cnt_q, fwd_mem_cnt_d;
  logic [CNT_W-1:0] fwd_wb_cnt_q, fwd_wb_cnt_d;
  logic [CNT_W-1:0] mem_inc, wb_inc;

  function automatic logic [CNT_W-1:0] sat_add(logic [CNT_W-1:0] a, logic [CNT_W-1:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  endfunction

  // Per-cycle increments, saturating at all-ones.
  always_comb begin
    mem_inc = '0;
    wb_inc  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (sel[i] == FWD_MEM) mem_inc = mem_inc + CNT_W'(1);
      if (sel[i] == FWD_WB)  wb_inc  = wb_inc + CNT_W'(1);
    end
    stall_cnt_d   = sat_add(stall_cnt_q, CNT_W'(stall));
    fwd_mem_cnt_d = sat_add(fwd_mem_cnt_q, mem_inc);
    fwd_wb_cnt_d  = sat_add(fwd_wb_cnt_q, wb_inc);
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q   <= '0;
      fwd_mem_cnt_q <= '0;
      fwd_wb_cnt_q  <= '0;
    end else begin
      stall_cnt_q   <= stall_cnt_d;
      fwd_mem_cnt_q <= fwd_mem_cnt_d;
      fwd_wb_cnt_q  <= fwd_wb_cnt_d;
    end
  end

  assign stall_cnt   = stall_cnt_q;
  assign fwd_mem_cnt = fwd_mem_cnt_q;
  assign fwd_wb_cnt  = fwd_wb_cnt_q;
`endif

endmodule

// File: tb/tb_bypass_network.sv
// Self-checking bench for bypass_network: directed pipeline scenarios followed by
// randomized instruction streams, checked against an in-flight instruction model.
module tb_bypass_network;
  import bypass_pkg::*;

  localparam int unsigned DataW  = 32;
  localparam int unsigned NumSrc = 2;
  localparam int unsigned RegW   = 5;
  localparam int unsigned CntW   = 4;
  localparam int unsigned CntMax = (1 << CntW) - 1;

  typedef struct packed {
    logic                       valid;
    logic                       we;
    logic                       ld;
    logic [RegW-1:0]            dst;
    logic [NumSrc-1:0][RegW-1:0] src;
  } ins_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bypass_network_if #(.DATA_W(DataW), .NUM_SRC(NumSrc), .REG_ADDR_W(RegW)) bus_if ();

`ifdef FWD_STATS_EN
  logic [CntW-1:0] stall_cnt, fwd_mem_cnt, fwd_wb_cnt;
  bypass_network #(
    .DATA_W(DataW), .NUM_SRC(NumSrc), .REG_ADDR_W(RegW), .CNT_W(CntW)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus_if),
    .stall_cnt(stall_cnt), .fwd_mem_cnt(fwd_mem_cnt), .fwd_wb_cnt(fwd_wb_cnt)
  );
`else
  bypass_network #(
    .DATA_W(DataW), .NUM_SRC(NumSrc), .REG_ADDR_W(RegW)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus_if)
  );
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // In-flight instructions, youngest first: [0]=EX, [1]=MEM, [2]=WB.
  ins_t pipe[$];
  int unsigned m_stall_cnt, m_mem_cnt, m_wb_cnt;
  logic last_stall;

  logic             obs_stall;
  logic [1:0]       obs_sel [NumSrc];
  logic [DataW-1:0] obs_fwd [NumSrc];
  logic [CntW-1:0]  obs_cnt [3];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic ins_t mk(input int dst, input bit we, input bit ld, input int s0, input int s1);
    ins_t r;
    r.valid  = 1'b1;
    r.we     = we;
    r.ld     = ld;
    r.dst    = RegW'(dst);
    r.src[0] = RegW'(s0);
    r.src[1] = RegW'(s1);
    return r;
  endfunction

  // Does instruction p deliver a value for register r?
  function automatic bit writes(input ins_t p, input logic [RegW-1:0] r);
    return p.valid && p.we && (p.dst != '0) && (p.dst == r);
  endfunction

  function automatic int unsigned sat(input int unsigned a, input int unsigned b);
    return (a + b > CntMax) ? CntMax : a + b;
  endfunction

  function automatic ins_t rand_ins();
    ins_t r;
    r.valid = ($urandom_range(7) != 0);
    r.we    = ($urandom_range(3) != 0);
    r.ld    = ($urandom_range(2) == 0);
    r.dst   = RegW'($urandom_range(4));
    for (int i = 0; i < NumSrc; i++) r.src[i] = RegW'($urandom_range(4));
    return r;
  endfunction

  // One pipeline cycle: drive ID/EX-side inputs, check outputs at negedge, advance the model.
  task automatic run_cycle(input ins_t id, input logic fl, input logic rs,
                           input logic [DataW-1:0] mem_v, input logic [DataW-1:0] wb_v,
                           input logic [NumSrc-1:0][DataW-1:0] ori);
    logic             exp_stall;
    logic [1:0]       exp_sel;
    logic [DataW-1:0] exp_dat;
    logic [RegW-1:0]  r;
    int unsigned      n_mem, n_wb;
    rst                = rs;
    bus_if.flush       = fl;
    bus_if.id_valid    = id.valid;
    bus_if.id_src_addr = id.src;
    bus_if.id_dst_addr = id.dst;
    bus_if.id_dst_we   = id.we;
    bus_if.id_is_load  = id.ld;
    bus_if.ex_src_data = ori;
    bus_if.mem_alu_out = mem_v;
    bus_if.wb_result   = wb_v;
    @(negedge clk);
    exp_stall = 1'b0;
    if (id.valid && !fl && writes(pipe[0], pipe[0].dst) && pipe[0].ld) begin
      for (int i = 0; i < NumSrc; i++) if (id.src[i] == pipe[0].dst) exp_stall = 1'b1;
    end
    obs_stall = bus_if.stall;
    check_eq("stall", obs_stall, exp_stall);
    n_mem = 0;
    n_wb  = 0;
    for (int i = 0; i < NumSrc; i++) begin
      r = pipe[0].src[i];
      if (writes(pipe[1], r) && !pipe[1].ld) begin
        exp_sel = 2'd1; exp_dat = mem_v; n_mem++;
      end else if (writes(pipe[2], r)) begin
        exp_sel = 2'd2; exp_dat = wb_v; n_wb++;
      end else begin
        exp_sel = 2'd0; exp_dat = ori[i];
      end
      obs_sel[i] = bus_if.fwd_sel[i*2 +: 2];
      obs_fwd[i] = bus_if.ex_src_fwd[i*DataW +: DataW];
      check_eq($sformatf("fwd_sel%0d", i), obs_sel[i], exp_sel);
      check_eq($sformatf("ex_src_fwd%0d", i), obs_fwd[i], exp_dat);
    end
`ifdef FWD_STATS_EN
    obs_cnt[0] = stall_cnt;
    obs_cnt[1] = fwd_mem_cnt;
    obs_cnt[2] = fwd_wb_cnt;
    check_eq("stall_cnt", obs_cnt[0], m_stall_cnt);
    check_eq("fwd_mem_cnt", obs_cnt[1], m_mem_cnt);
    check_eq("fwd_wb_cnt", obs_cnt[2], m_wb_cnt);
`endif
    @(posedge clk);
    #1;
    if (rs) begin
      pipe        = '{ins_t'(0), ins_t'(0), ins_t'(0)};
      m_stall_cnt = 0;
      m_mem_cnt   = 0;
      m_wb_cnt    = 0;
      last_stall  = 1'b0;
    end else begin
      pipe.push_front((exp_stall || fl) ? ins_t'(0) : id);
      void'(pipe.pop_back());
      m_stall_cnt = sat(m_stall_cnt, int'(exp_stall));
      m_mem_cnt   = sat(m_mem_cnt, n_mem);
      m_wb_cnt    = sat(m_wb_cnt, n_wb);
      last_stall  = exp_stall;
    end
  endtask

  task automatic dcycle(input ins_t id, input logic fl, input logic [DataW-1:0] ori0);
    run_cycle(id, fl, 1'b0, 32'h0000_0010, 32'h0000_00AB, {32'h0000_0022, ori0});
  endtask

  ins_t nop, cur;
  logic rfl, rrs;

  initial begin
    nop  = '0;
    pipe = '{ins_t'(0), ins_t'(0), ins_t'(0)};
    m_stall_cnt = 0; m_mem_cnt = 0; m_wb_cnt = 0;
    last_stall  = 1'b0;

    // Reset state: no forwarding, operands pass through.
    run_cycle(nop, 1'b0, 1'b1, 32'h5, 32'h6, {32'h77, 32'h88});
    check_eq("rst_sel0", obs_sel[0], 2'd0);
    check_eq("rst_fwd0", obs_fwd[0], 32'h88);
    run_cycle(nop, 1'b0, 1'b1, 32'h5, 32'h6, {32'h77, 32'h88});

    // add r3 ; sub r4,r3,r1 -> MEM forward.
    dcycle(mk(3, 1, 0, 1, 2), 1'b0, 32'h11);
    dcycle(mk(4, 1, 0, 3, 1), 1'b0, 32'h11);
    dcycle(nop, 1'b0, 32'h11);
    check_eq("t1_sel0", obs_sel[0], 2'd1);
    check_eq("t1_fwd0", obs_fwd[0], 32'h10);
    check_eq("t1_stall", obs_stall, 1'b0);

    // add r3 ; nop ; or r5,r3,r3 -> both sources from WB.
    dcycle(mk(3, 1, 0, 1, 2), 1'b0, 32'h11);
    dcycle(nop, 1'b0, 32'h11);
    dcycle(mk(5, 1, 0, 3, 3), 1'b0, 32'h11);
    dcycle(nop, 1'b0, 32'h11);
    check_eq("t2_sel0", obs_sel[0], 2'd2);
    check_eq("t2_sel1", obs_sel[1], 2'd2);
    check_eq("t2_fwd1", obs_fwd[1], 32'hAB);

    // add r3 ; xor r3 ; consumer -> MEM beats WB.
    dcycle(mk(3, 1, 0, 1, 2), 1'b0, 32'h11);
    dcycle(mk(3, 1, 0, 2, 1), 1'b0, 32'h11);
    dcycle(mk(7, 1, 0, 3, 1), 1'b0, 32'h11);
    dcycle(nop, 1'b0, 32'h11);
    check_eq("t3_sel0", obs_sel[0], 2'd1);
    check_eq("t3_fwd0", obs_fwd[0], 32'h10);

    // lw r2 ; add r6,r2,r7 -> one stall, then WB forward of load data.
    dcycle(mk(2, 1, 1, 1, 1), 1'b0, 32'h11);
    dcycle(mk(6, 1, 0, 2, 7), 1'b0, 32'h11);
    check_eq("t4_stall", obs_stall, 1'b1);
    dcycle(mk(6, 1, 0, 2, 7), 1'b0, 32'h11);
    check_eq("t4_stall_end", obs_stall, 1'b0);
    dcycle(nop, 1'b0, 32'h11);
    check_eq("t4_sel0", obs_sel[0], 2'd2);
    check_eq("t4_fwd0", obs_fwd[0], 32'hAB);

    // Write r0 then read r0 -> never forwarded.
    dcycle(mk(0, 1, 0, 1, 2), 1'b0, 32'h0);
    dcycle(mk(8, 1, 0, 0, 0), 1'b0, 32'h0);
    dcycle(nop, 1'b0, 32'h0);
    check_eq("t5_sel0", obs_sel[0], 2'd0);
    check_eq("t5_fwd0", obs_fwd[0], 32'h0);

    // Flush during a load-use stall: stall drops and the consumer is squashed.
    dcycle(mk(2, 1, 1, 1, 1), 1'b0, 32'h11);
    dcycle(mk(4, 1, 0, 2, 2), 1'b1, 32'h11);
    check_eq("t6_stall", obs_stall, 1'b0);
    dcycle(mk(9, 1, 0, 4, 4), 1'b0, 32'h11);
    dcycle(nop, 1'b0, 32'h11);
    check_eq("t6_sel0", obs_sel[0], 2'd0);

    // Reset mid-stall.
    dcycle(mk(2, 1, 1, 1, 1), 1'b0, 32'h11);
    run_cycle(mk(6, 1, 0, 2, 2), 1'b0, 1'b1, 32'h10, 32'hAB, {32'h22, 32'h11});
    dcycle(mk(6, 1, 0, 2, 2), 1'b0, 32'h11);
    check_eq("t7_stall", obs_stall, 1'b0);
    check_eq("t7_sel0", obs_sel[0], 2'd0);
`ifdef FWD_STATS_EN
    check_eq("t7_stall_cnt", obs_cnt[0], 0);
`endif

    // Randomized instruction stream; ID holds while stalled.
    cur = nop;
    for (int n = 0; n < 3000; n++) begin
      rfl = ($urandom_range(15) == 0);
      rrs = ($urandom_range(99) == 0);
      if (!last_stall) cur = rand_ins();
      run_cycle(cur, rfl, rrs, $urandom, $urandom, {$urandom, $urandom});
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
